// File: rtl/tone_pkg.sv
// tone_pkg: shared definitions for the tone sequencer.
//   - state_e     : sequencer FSM encoding (IDLE / PLAY / GAP)
//   - NOTE_REST / NOTE_MAX : pitch code limits (1..24 = C4..B5 chromatic)
//   - centi_hz()  : note frequency table in 1/100 Hz
//   - arr_of()    : PWM period in clock cycles for a note, 0 for rests
//   - crr_of()    : compare value for a volume level
package tone_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam logic [4:0] NOTE_REST = 5'd0;
  localparam logic [4:0] NOTE_MAX  = 5'd24;

  // Equal-tempered frequencies, C4..B5, in centi-Hz. Codes outside 1..24 are rests.
  function automatic int unsigned centi_hz(input logic [4:0] code);
    case (code)
      5'd1:    return 26163;
      5'd2:    return 27718;
      5'd3:    return 29366;
      5'd4:    return 31113;
      5'd5:    return 32963;
      5'd6:    return 34923;
      5'd7:    return 36999;
      5'd8:    return 39200;
      5'd9:    return 41530;
      5'd10:   return 44000;
      5'd11:   return 46616;
      5'd12:   return 49388;
      5'd13:   return 52325;
      5'd14:   return 55437;
      5'd15:   return 58733;
      5'd16:   return 62225;
      5'd17:   return 65926;
      5'd18:   return 69846;
      5'd19:   return 73999;
      5'd20:   return 78399;
      5'd21:   return 83061;
      5'd22:   return 88000;
      5'd23:   return 93233;
      5'd24:   return 98777;
      default: return 0;
    endcase
  endfunction

  // Period = clk_hz / f, rounded down. 64-bit intermediate because
  // clk_hz*100 overflows 32 bits at 100 MHz. Only ever called with
  // constant arguments, so no divider is built.
  function automatic logic [31:0] arr_of(input logic [4:0] code, input int unsigned clk_hz);
    longint unsigned f;
    longint unsigned num;
    f   = 64'(centi_hz(code));
    num = 64'(clk_hz) * 64'd100;
    if (f == 64'd0) return 32'd0;
    return 32'(num / f);
  endfunction

  // Duty 1/2, 1/4, 1/8 for volume 3, 2, 1; volume 0 is silent.
  function automatic logic [31:0] crr_of(input logic [31:0] arr, input logic [1:0] vol);
    case (vol)
      2'd3:    return arr >> 1;
      2'd2:    return arr >> 2;
      2'd1:    return arr >> 3;
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/note_lut.sv
// note_lut: combinational ROM from 5-bit pitch code to 32-bit PWM period.
//   code : pitch code (0 and 25..31 are rests)
//   arr  : period in clock cycles, 0 for rest codes
// Every entry is an elaboration-time constant.
module note_lut
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic [4:0]  code,
  output logic [31:0] arr
);

  logic [31:0] rom [32];

  for (genvar i = 0; i < 32; i++) begin : g_rom
    localparam logic [31:0] ENTRY = arr_of(5'(i), CLK_HZ);
    assign rom[i] = ENTRY;
  end

  assign arr = rom[code];

endmodule

// File: rtl/tone_seq.sv
// tone_seq: one-note-at-a-time sequencer feeding the buzzer PWM generator.
//   clk, reset_n            : clock, asynchronous active-low reset
//   req_valid / req_ready   : note request handshake
//   req_note/vol/dur_ms     : pitch code, volume, length in ms
//   abort                   : drop the current note (and its gap) at once
//   busy                    : high whenever the FSM is not IDLE
//   done                    : one-cycle pulse on normal completion
//   pwm_gen_en, counter_arr, counter_crr : generator controls (registered)
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high and abort is low. req_ready is high exactly
// when the FSM is IDLE; req_* are sampled only on that edge.
module tone_seq
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned GAP_MS = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_note,
  input  logic [1:0]  req_vol,
  input  logic [15:0] req_dur_ms,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        pwm_gen_en,
  output logic [31:0] counter_arr,
  output logic [31:0] counter_crr
);

  localparam int unsigned TICK_DIV  = CLK_HZ / 1000;
  localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
  localparam logic [15:0] GAP_LOAD  = 16'(GAP_MS);
  localparam bit          HAS_GAP   = (GAP_MS != 0);

  state_e      state_q, state_d;
  logic [31:0] presc_q, presc_d;
  logic [15:0] ms_q, ms_d;
  logic        done_q, done_d;
  logic        en_q, en_d;
  logic [31:0] arr_q, arr_d;
  logic [31:0] crr_q, crr_d;

  logic [31:0] lut_arr;
  logic        accept;
  logic        audible;
  logic        tick;

  note_lut #(.CLK_HZ(CLK_HZ)) u_lut (
    .code (req_note),
    .arr  (lut_arr)
  );

  assign accept  = req_valid && req_ready && !abort;
  assign audible = (req_note != NOTE_REST) && (req_note <= NOTE_MAX) && (req_vol != 2'd0);
  assign tick    = (presc_q == TICK_LAST);

  // The note and volume are captured directly as arr/crr at accept, so
  // those registers are the latched request.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    ms_d    = ms_q;
    done_d  = 1'b0;
    en_d    = en_q;
    arr_d   = arr_q;
    crr_d   = crr_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          presc_d = 32'd0;
          if (req_dur_ms == 16'd0) begin
            // Zero-length note: skip PLAY, outputs stay silent.
            en_d = 1'b0;
            if (HAS_GAP) begin
              state_d = ST_GAP;
              ms_d    = GAP_LOAD;
            end else begin
              done_d = 1'b1;
              ms_d   = 16'd0;
            end
          end else begin
            state_d = ST_PLAY;
            ms_d    = req_dur_ms;
            en_d    = audible;
            arr_d   = audible ? lut_arr : 32'd0;
            crr_d   = audible ? crr_of(lut_arr, req_vol) : 32'd0;
          end
        end
      end

      ST_PLAY, ST_GAP: begin
        if (abort) begin
          state_d = ST_IDLE;
          presc_d = 32'd0;
          ms_d    = 16'd0;
          en_d    = 1'b0;
        end else if (tick) begin
          presc_d = 32'd0;
          if (ms_q == 16'd1) begin
            en_d = 1'b0;
            if (state_q == ST_PLAY && HAS_GAP) begin
              state_d = ST_GAP;
              ms_d    = GAP_LOAD;
            end else begin
              state_d = ST_IDLE;
              ms_d    = 16'd0;
              done_d  = 1'b1;
            end
          end else begin
            ms_d = ms_q - 16'd1;
          end
        end else begin
          presc_d = presc_q + 32'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      presc_q <= 32'd0;
      ms_q    <= 16'd0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      arr_q   <= 32'd0;
      crr_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      ms_q    <= ms_d;
      done_q  <= done_d;
      en_q    <= en_d;
      arr_q   <= arr_d;
      crr_q   <= crr_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign pwm_gen_en  = en_q;
  assign counter_arr = arr_q;
  assign counter_crr = crr_q;

endmodule

// File: tb/tb_tone_seq.sv
// tb_tone_seq: directed bench for tone_seq at CLK_HZ=1 MHz, GAP_MS=2
// (1000 cycles per ms). Expected periods are hand-derived from
// 1e8 / centi-Hz: C4=3822, A4=2272, C5=1911, B5=1012.
module tb_tone_seq;

  localparam int LIMIT = 20000;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_note;
  logic [1:0]  req_vol;
  logic [15:0] req_dur_ms;
  logic        abort;
  logic        busy;
  logic        done;
  logic        pwm_gen_en;
  logic [31:0] counter_arr;
  logic [31:0] counter_crr;

  int err_cnt = 0;
  int chk_cnt = 0;

  tone_seq #(.CLK_HZ(1_000_000), .GAP_MS(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_note    (req_note),
    .req_vol     (req_vol),
    .req_dur_ms  (req_dur_ms),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .pwm_gen_en  (pwm_gen_en),
    .counter_arr (counter_arr),
    .counter_crr (counter_crr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one request; returns just after the accept edge.
  task automatic send(input logic [4:0] note, input logic [1:0] vol, input logic [15:0] dur);
    @(negedge clk);
    req_valid  = 1'b1;
    req_note   = note;
    req_vol    = vol;
    req_dur_ms = dur;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Follow one note from the cycle after accept to its done cycle.
  task automatic observe(input string tag, input int exp_busy, input int exp_en,
                         input logic chk_arr, input logic [31:0] exp_arr,
                         input logic [31:0] exp_crr);
    int busy_cyc, en_cyc, first_en, last_en, arr_bad, done_early, idx;
    busy_cyc = 0; en_cyc = 0; first_en = -1; last_en = -1;
    arr_bad = 0; done_early = 0; idx = 0;
    @(negedge clk);
    while (busy === 1'b1 && idx < LIMIT) begin
      busy_cyc++;
      if (pwm_gen_en === 1'b1) begin
        en_cyc++;
        if (first_en < 0) first_en = idx;
        last_en = idx;
      end
      if (chk_arr && (counter_arr !== exp_arr || counter_crr !== exp_crr)) arr_bad++;
      if (done !== 1'b0) done_early++;
      idx++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, busy_cyc, exp_busy);
    check({tag, "_en_cycles"}, en_cyc, exp_en);
    check({tag, "_en_first"}, first_en, (exp_en > 0) ? 0 : -1);
    check({tag, "_en_last"}, last_en, exp_en - 1);
    check({tag, "_arr_crr_bad"}, arr_bad, 0);
    check({tag, "_done_early"}, done_early, 0);
    check({tag, "_done_pulse"}, done, 1);
    check({tag, "_ready_after"}, req_ready, 1);
    @(negedge clk);
    check({tag, "_done_single"}, done, 0);
  endtask

  initial begin
    int bad, dcnt, busy_cyc, en_cyc, done_pos0, done_pos1, idle_cyc;
    logic [31:0] arr_a, crr_a, arr_b, crr_b;

    reset_n = 1'b0; req_valid = 1'b0; req_note = '0; req_vol = '0;
    req_dur_ms = '0; abort = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // reset state, held with no requests
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || pwm_gen_en !== 1'b0 ||
          counter_arr !== 32'd0 || counter_crr !== 32'd0) bad++;
    end
    check("reset_idle_bad", bad, 0);
    check("reset_arr", counter_arr, 0);
    check("reset_ready", req_ready, 1);

    // A4, vol 3, 5 ms: 5000 en cycles, 2000 gap
    send(5'd10, 2'd3, 16'd5);
    observe("a4", 7000, 5000, 1'b1, 32'd2272, 32'd1136);

    // rest keeps timing, outputs silent
    send(5'd0, 2'd2, 16'd3);
    observe("rest", 5000, 0, 1'b1, 32'd0, 32'd0);

    // C4 vol 1, abort at PLAY cycle 1500
    send(5'd1, 2'd1, 16'd4);
    @(negedge clk);
    check("c4_arr", counter_arr, 3822);
    check("c4_crr", counter_crr, 477);
    check("c4_en", pwm_gen_en, 1);
    repeat (1499) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_en", pwm_gen_en, 0);
    check("abort_done", done, 0);
    check("abort_ready", req_ready, 1);
    dcnt = 0;
    repeat (3000) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) dcnt++;
    end
    check("abort_no_done", dcnt, 0);

    // abort in IDLE blocks acceptance for that cycle
    @(negedge clk);
    req_valid = 1'b1; req_note = 5'd10; req_vol = 2'd2; req_dur_ms = 16'd1; abort = 1'b1;
    @(negedge clk);
    check("idle_abort_blocks", busy, 0);
    abort = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    observe("a4_vol2", 3000, 1000, 1'b1, 32'd2272, 32'd568);

    // back-to-back with req_valid held; fields change mid-note
    @(negedge clk);
    req_valid = 1'b1; req_note = 5'd13; req_vol = 2'd3; req_dur_ms = 16'd1;
    @(posedge clk);
    busy_cyc = 0; en_cyc = 0; done_pos0 = -1; done_pos1 = -1; idle_cyc = 0; bad = 0;
    arr_a = '0; crr_a = '0; arr_b = '0; crr_b = '0;
    for (int i = 0; i <= 6001; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cyc++; else idle_cyc++;
      if (pwm_gen_en === 1'b1) en_cyc++;
      if (done === 1'b1) begin
        if (done_pos0 < 0) done_pos0 = i; else done_pos1 = i;
      end
      if (i < 3000 && counter_arr !== 32'd1911) bad++;
      if (i == 0) begin
        arr_a = counter_arr; crr_a = counter_crr;
        req_note = 5'd24; req_vol = 2'd1;
      end
      if (i == 3001) begin
        arr_b = counter_arr; crr_b = counter_crr;
        req_valid = 1'b0;
      end
    end
    check("b2b_busy_total", busy_cyc, 6000);
    check("b2b_idle_cycles", idle_cyc, 2);
    check("b2b_en_cycles", en_cyc, 2000);
    check("b2b_done0_pos", done_pos0, 3000);
    check("b2b_done1_pos", done_pos1, 6001);
    check("b2b_arr1", arr_a, 1911);
    check("b2b_crr1", crr_a, 955);
    check("b2b_arr1_hold", bad, 0);
    check("b2b_arr2", arr_b, 1012);
    check("b2b_crr2", crr_b, 126);
    @(negedge clk);

    // zero-length note: gap only
    send(5'd10, 2'd3, 16'd0);
    observe("dur0", 2000, 0, 1'b0, 32'd0, 32'd0);

    // zero-length note, reset pulsed mid-gap
    send(5'd10, 2'd3, 16'd0);
    repeat (1000) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    check("pre_reset_arr", counter_arr, 1012);
    reset_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 1);
    check("rst_en", pwm_gen_en, 0);
    check("rst_arr", counter_arr, 0);
    check("rst_crr", counter_crr, 0);
    @(negedge clk);
    reset_n = 1'b1;
    dcnt = 0;
    repeat (2500) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) dcnt++;
    end
    check("rst_no_done", dcnt, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/tone_seq.md
Name: tone_seq

Overview:
- Note sequencer that sits directly upstream of the buzzer PWM generator.
- Accepts one note request at a time (pitch code, volume, duration in ms) over a valid/ready handshake.
- Drives the generator's enable, period (arr) and compare (crr) inputs, then inserts a fixed silent gap.
- Used for lane hit sounds and short melodies in the 4-key game.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- GAP_MS, 10, silence inserted after every note, in ms; 0 means no gap.
- TICK_DIV, CLK_HZ/1000, cycles per ms tick (derived; not overridden).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  note request present
- req_ready  out  1  block can accept a request
- req_note  in  5  pitch code: 0 = rest, 1..24 = C4..B5 chromatic, 25..31 = rest
- req_vol  in  2  volume: 0 = mute, 1..3 = duty 1/8, 1/4, 1/2
- req_dur_ms  in  16  note length in ms
- abort  in  1  stop the current note immediately
- busy  out  1  high when not IDLE
- done  out  1  one-cycle pulse at normal note completion
- pwm_gen_en  out  1  enable to PWM generator
- counter_arr  out  32  period value to PWM generator
- counter_crr  out  32  compare value to PWM generator

Behaviour:
- Reset values: state IDLE, req_ready=1, busy=0, done=0, pwm_gen_en=0, counter_arr=0, counter_crr=0, tick prescaler=0, ms counter=0.
- States: IDLE, PLAY, GAP.
- IDLE:
  - req_ready=1.
  - Request is accepted on the edge where req_valid&req_ready.
  - On accept: latch note/vol/dur, clear the prescaler, load the ms counter with req_dur_ms.
  - Go to PLAY; if req_dur_ms==0, go straight to GAP (or IDLE with done if GAP_MS==0).
- PLAY:
  - req_ready=0.
  - Outputs are registered and valid the cycle after accept.
  - counter_arr = LUT period for the note.
  - counter_crr = arr>>1 / arr>>2 / arr>>3 for vol 3 / 2 / 1.
  - pwm_gen_en=1 unless the note is a rest or vol==0. For rest or mute: en=0, arr=crr=0, timing is unchanged.
  - The prescaler counts 0..TICK_DIV-1. On wrap, the ms counter decrements.
  - When the ms counter reaches 0, go to GAP. PLAY lasts exactly dur*TICK_DIV cycles.
- GAP:
  - pwm_gen_en=0; arr/crr hold their last value.
  - Lasts GAP_MS*TICK_DIV cycles, then go to IDLE with done=1 on the cycle IDLE is entered.
  - A back-to-back request can be accepted the cycle after done.
- abort:
  - In PLAY or GAP: next edge goes to IDLE, en=0, no done pulse, prescaler and counter cleared.
  - In IDLE: abort is ignored, but it blocks acceptance that cycle (abort has priority over req_valid).
- busy = (state != IDLE).
- Period arithmetic: arr = CLK_HZ / f_note, rounded down, computed at elaboration as 32-bit constants. No runtime division.
- Reset asserted mid-note: all outputs return to reset values asynchronously.
- req_* are sampled only at accept; changes during PLAY are ignored.

Decomposition:
- Package tone_pkg:
  - state encoding (IDLE, PLAY, GAP)
  - NOTE_REST=0, NOTE_MAX=24
  - note frequency table in centi-Hz, C4=26163 … B5=98777
  - function arr_of(code, clk_hz)
- Sub-module note_lut: combinational ROM, 5-bit code to 32-bit arr. Out-of-range codes return 0.

Test Plan (all with CLK_HZ=1_000_000, TICK_DIV=1000, GAP_MS=2):
- Reset, no requests -> req_ready=1, busy=0, en=0, arr=crr=0 indefinitely.
- Request note=10 (A4), vol=3, dur=5, accepted at cycle k:
  - from k+1: arr=2272, crr=1136, en=1 for exactly 5000 cycles
  - then en=0 for 2000 cycles
  - done pulses once; req_ready returns high.
- Request note=0, vol=2, dur=3 -> en=0 and arr=0 for 3000 cycles, then gap, done pulses (rest keeps timing).
- Request note=1 (C4), vol=1, dur=4; assert abort at cycle 1500 of PLAY -> next cycle state IDLE, en=0, no done, req_ready=1.
- Hold req_valid high with two queued requests (dur=1 each) -> second accepted the cycle after the first done. Total busy span is 2*(1000+2000) cycles, separated by one idle cycle.
- dur=0 request -> no PLAY cycles (en never 1), GAP of 2000 cycles, then done; reset_n pulsed low mid-GAP -> outputs zero immediately, no done.
